// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch unit bus: instruction-memory read port, decode handshake,
// branch redirect input and status outputs.
interface instr_fetch_unit_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic        active;

    // Fetch unit side
    modport master (
        output instr_address, instr_read, instr_out, instr_valid, pc_out, active,
        input  instr_waitrequest, instr_readdata, instr_ready, branch_valid, branch_target
    );

    // Memory / decode / branch-resolution side
    modport slave (
        input  instr_address, instr_read, instr_out, instr_valid, pc_out, active,
        output instr_waitrequest, instr_readdata, instr_ready, branch_valid, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads, hands each fetched
// instruction to decode and applies MIPS delay-slot branch redirection.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] PC_STEP      = 32'h00000004,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_HALTED
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   instr_out_q;
    logic              instr_read_q;
    logic              instr_valid_q;
    logic              active_q;
    logic              pending_q;
    logic [XLEN-1:0]   pend_target_q;

    logic              accept;
    logic [XLEN-1:0]   next_pc_d;
    logic [XLEN-1:0]   branch_tgt;

    // Accept detection, redirect target alignment and next-PC selection
    always_comb begin
        accept     = 1'b0;
        next_pc_d  = pc_q + PC_STEP;
        branch_tgt = bus.branch_target & ~XLEN'(3);
        if (state_q == ST_HOLD && bus.instr_ready) begin
            accept = 1'b1;
        end
        if (pending_q) begin
            next_pc_d = pend_target_q;
        end
    end

    // Fetch sequencing FSM with registered bus and status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_out_q   <= '0;
            instr_read_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            active_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q      <= ST_FETCH;
                    instr_read_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (!bus.instr_waitrequest) begin
                        instr_out_q   <= bus.instr_readdata;
                        instr_read_q  <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= next_pc_d;
                        if (next_pc_d == HALT_ADDR) begin
                            state_q  <= ST_HALTED;
                            active_q <= 1'b0;
                        end else begin
                            state_q      <= ST_FETCH;
                            instr_read_q <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    instr_read_q  <= 1'b0;
                    instr_valid_q <= 1'b0;
                    active_q      <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pending delay-slot redirect: a new branch always wins, an accept consumes it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q     <= 1'b0;
            pend_target_q <= '0;
        end else if (state_q != ST_HALTED) begin
            if (bus.branch_valid) begin
                pending_q     <= 1'b1;
                pend_target_q <= branch_tgt;
            end else if (accept) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.instr_address = pc_q;
    assign bus.pc_out        = pc_q;
    assign bus.instr_read    = instr_read_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr_out     = instr_out_q;
    assign bus.active        = active_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle behavioural model plus directed and
// randomized stimulus.
module tb_instr_fetch_unit;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset_n;

    instr_fetch_unit_if ifc();

    instr_fetch_unit #(
        .RESET_VECTOR(RV),
        .PC_STEP     (32'h00000004),
        .HALT_ADDR   (32'h00000000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = just out of reset, 1 = read outstanding, 2 = instruction offered, 3 = halted
    int          m_phase;
    int          old_phase;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] m_out;
    logic [31:0] nxt;
    logic        m_pend;
    bit          m_init = 0;
    bit          acc;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_phase = 0;
                m_pc    = RV;
                m_pend  = 1'b0;
                m_tgt   = 32'h0;
                m_out   = 32'h0;
                m_init  = 1;
            end else if (m_init) begin
                old_phase = m_phase;
                acc = (m_phase == 2) && (ifc.instr_ready == 1'b1);
                if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    if (!ifc.instr_waitrequest) begin
                        m_out   = ifc.instr_readdata;
                        m_phase = 2;
                    end
                end else if (acc) begin
                    nxt     = m_pend ? m_tgt : m_pc + 32'd4;
                    m_pc    = nxt;
                    m_phase = (nxt == 32'h0) ? 3 : 1;
                end
                if (old_phase != 3) begin
                    if (ifc.branch_valid) begin
                        m_pend = 1'b1;
                        m_tgt  = {ifc.branch_target[31:2], 2'b00};
                    end else if (acc) begin
                        m_pend = 1'b0;
                    end
                end
            end
            #1;
            if (m_init) begin
                check("model instr_read",    32'(ifc.instr_read),  32'(m_phase == 1));
                check("model instr_valid",   32'(ifc.instr_valid), 32'(m_phase == 2));
                check("model active",        32'(ifc.active),      32'(m_phase != 3));
                check("model pc_out",        ifc.pc_out,           m_pc);
                check("model instr_address", ifc.instr_address,    m_pc);
                check("model instr_out",     ifc.instr_out,        m_out);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_read(input string name, input logic [31:0] exp_addr);
        int k = 0;
        while (ifc.instr_read !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, " read"}, 32'(ifc.instr_read), 32'd1);
        check({name, " addr"}, ifc.instr_address, exp_addr);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (ifc.instr_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, " valid"}, 32'(ifc.instr_valid), 32'd1);
    endtask

    task automatic accept_one(input string name);
        wait_valid(name);
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        ifc.instr_ready = 1'b0;
    endtask

    task automatic branch_accept(input string name, input logic [31:0] tgt);
        wait_valid(name);
        ifc.branch_valid  = 1'b1;
        ifc.branch_target = tgt;
        ifc.instr_ready   = 1'b1;
        @(negedge clk);
        ifc.branch_valid  = 1'b0;
        ifc.instr_ready   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_halted(input string name);
        check({name, " active"}, 32'(ifc.active),      32'd0);
        check({name, " read"},   32'(ifc.instr_read),  32'd0);
        check({name, " valid"},  32'(ifc.instr_valid), 32'd0);
        check({name, " pc"},     ifc.pc_out,           32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n               = 1'b0;
        ifc.instr_waitrequest = 1'b0;
        ifc.instr_readdata    = 32'h0;
        ifc.instr_ready       = 1'b0;
        ifc.branch_valid      = 1'b0;
        ifc.branch_target     = 32'h0;
        repeat (2) @(negedge clk);

        check("reset read",   32'(ifc.instr_read),  32'd0);
        check("reset valid",  32'(ifc.instr_valid), 32'd0);
        check("reset active", 32'(ifc.active),      32'd1);
        check("reset pc",     ifc.pc_out,           RV);
        check("reset out",    ifc.instr_out,        32'h0);

        // First fetch: read one cycle after release, data valid the next
        ifc.instr_readdata = 32'h24020005;
        reset_n = 1'b1;
        @(negedge clk);
        check("first read", 32'(ifc.instr_read), 32'd1);
        check("first addr", ifc.instr_address,   RV);
        @(negedge clk);
        check("first valid", 32'(ifc.instr_valid), 32'd1);
        check("first out",   ifc.instr_out,         32'h24020005);
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        ifc.instr_ready = 1'b0;
        check("no b2b valid", 32'(ifc.instr_valid), 32'd0);
        wait_read("seq", RV + 32'h4);

        // Memory stall for 3 cycles: address held, one instruction delivered
        ifc.instr_waitrequest = 1'b1;
        ifc.instr_readdata    = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            check("stall read", 32'(ifc.instr_read), 32'd1);
            check("stall addr", ifc.instr_address,   RV + 32'h4);
        end
        ifc.instr_waitrequest = 1'b0;
        ifc.instr_readdata    = 32'h8C430010;
        @(negedge clk);
        check("stall done valid", 32'(ifc.instr_valid), 32'd1);
        check("stall done out",   ifc.instr_out,         32'h8C430010);

        // Decode back-pressure for 5 cycles
        repeat (5) begin
            ifc.instr_readdata = $urandom;
            @(negedge clk);
            check("hold valid", 32'(ifc.instr_valid), 32'd1);
            check("hold read",  32'(ifc.instr_read),  32'd0);
            check("hold out",   ifc.instr_out,         32'h8C430010);
        end
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        ifc.instr_ready = 1'b0;
        wait_read("after hold", RV + 32'h8);

        // Delay-slot branch taken on the instruction at +0x10
        accept_one("i08");
        wait_read("i0c", RV + 32'hC);
        accept_one("i0c");
        wait_read("i10", RV + 32'h10);
        branch_accept("br10", 32'hBFC00103);
        wait_read("delay slot", RV + 32'h14);
        accept_one("i14");
        wait_read("branch tgt", 32'hBFC00100);
        accept_one("i100");
        wait_read("i104", 32'hBFC00104);

        // Redirect near the top of the address space: PC wraps to 0 and halts
        branch_accept("br104", 32'hFFFFFFFB);
        wait_read("i108", 32'hBFC00108);
        accept_one("i108");
        wait_read("top-8", 32'hFFFFFFF8);
        accept_one("itop8");
        wait_read("top-4", 32'hFFFFFFFC);
        accept_one("itop4");
        check_halted("wrap halt");

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ifc.instr_waitrequest = ($urandom_range(0, 3) == 0);
            ifc.instr_readdata    = $urandom;
            ifc.instr_ready       = 1'($urandom_range(0, 1));
            ifc.branch_valid      = ($urandom_range(0, 7) == 0);
            ifc.branch_target     = $urandom | 32'h00000100;
            reset_n = !((ifc.active !== 1'b1) || ($urandom_range(0, 199) == 0));
            @(negedge clk);
        end
        ifc.instr_waitrequest = 1'b0;
        ifc.instr_ready       = 1'b0;
        ifc.branch_valid      = 1'b0;

        // Branch to address 0 (low bits ignored): halt after the delay slot
        do_reset();
        branch_accept("br0", 32'h00000003);
        wait_read("br0 slot", RV + 32'h4);
        accept_one("br0 slot");
        check_halted("halt");
        for (int i = 0; i < 10; i++) begin
            ifc.branch_valid  = 1'($urandom_range(0, 1));
            ifc.branch_target = $urandom;
            ifc.instr_ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_halted("halted idle");
        end
        ifc.branch_valid = 1'b0;
        ifc.instr_ready  = 1'b0;

        // Reset in the middle of a stalled fetch with a branch pending
        do_reset();
        wait_read("pre-reset", RV);
        ifc.instr_waitrequest = 1'b1;
        ifc.branch_valid      = 1'b1;
        ifc.branch_target     = 32'h12345678;
        @(negedge clk);
        ifc.branch_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset read",  32'(ifc.instr_read),  32'd0);
        check("midreset valid", 32'(ifc.instr_valid), 32'd0);
        check("midreset pc",    ifc.pc_out,           RV);
        reset_n = 1'b1;
        ifc.instr_waitrequest = 1'b0;
        @(negedge clk);
        check("restart read", 32'(ifc.instr_read), 32'd1);
        check("restart addr", ifc.instr_address,   RV);
        accept_one("restart");
        wait_read("pending cleared", RV + 32'h4);
        accept_one("final");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
